sound_arbiter: RTL and testbench
================================

# sound_arbiter

Shares the single board audio output (AUD_PWM/AUD_SD) between N game-event sources that each request a sound effect with a one-cycle `play_sound`-style pulse. It latches requests, grants the audio channel by fixed priority, and times each effect's duration and inter-effect gap. It also generates the square-wave tone for the granted effect. Sits between the game logic and the top-level audio pins of `nexys_arcade_top`.

## Interface
- `N_REQ`, 4: number of requesters; index 0 is the highest priority.
- `TONE_W`, 16: width of a tone half-period, in clk cycles.
- `DUR_W`, 24: width of an effect duration, in clk cycles.
- `GAP_CYC`, 1000: silent cycles between consecutive effects; 0 means no gap.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  one-cycle request pulses.
- `req_tone`  in  N_REQ*TONE_W  per-requester half-period; slice i is `[i*TONE_W +: TONE_W]`; held static by the source.
- `req_dur`  in  N_REQ*DUR_W  per-requester duration; slice i as above; held static by the source.
- `grant`  out  N_REQ  one-hot index of the playing effect; 0 when not in PLAY.
- `busy`  out  1  1 in PLAY or GAP.
- `pending`  out  N_REQ  latched, not-yet-served requests.
- `aud_pwm`  out  1  square-wave tone output.
- `aud_sd`  out  1  amplifier enable; 1 in PLAY and GAP.

## Operation
- FSM states: IDLE, PLAY, GAP.
- Effective request set `eff = pending | req`. Priority pick is the lowest set index of `eff`.
- **IDLE**
  - If `eff` is nonzero, go to PLAY at the next edge.
  - On that edge: set `grant`, load `dur_cnt = max(req_dur[i],1)`, load `tone_reg = max(req_tone[i],1)`, clear `pending[i]`.
- **PLAY**
  - `dur_cnt` decrements every cycle.
  - When it reaches 1, go to GAP at the next edge (or straight to the next grant / IDLE if `GAP_CYC == 0`).
  - `grant` clears on leaving PLAY.
- **GAP**
  - `gap_cnt` counts `GAP_CYC` cycles, with `aud_pwm` held at 0.
  - At the end: grant the next effect if `eff` is nonzero, else go to IDLE.
- **Pending capture:** `req[i]` sets `pending[i]` every cycle, except when that same edge grants i (the request is consumed).
  - Re-requesting the currently playing i sets `pending[i]`, so the effect replays after the gap.
  - Duplicate pulses while pending are merged.
- **Tone generation**
  - `tone_cnt` counts 0..`tone_reg`-1; `aud_pwm` toggles when it wraps.
  - Counter and output start at 0 on every grant, so the first edge of `aud_pwm` comes `tone_reg` cycles after grant.
  - Outside PLAY, `aud_pwm` = 0.
- **Reset values:** state IDLE; `grant`, `pending`, `busy`, `aud_pwm`, `aud_sd`, and all counters = 0. Reset mid-effect silences the output immediately, asynchronously.

## Timing
- Request latency from IDLE: `req` high at edge k, `grant`/`busy`/`aud_sd` = 1 after edge k. Latency is 1 cycle.
- `grant` is high for exactly `max(dur,1)` cycles.
- `busy` low-to-high handover: the next effect's `grant` rises exactly `GAP_CYC` cycles after the previous `grant` falls.
- Back-to-back grants occur with no IDLE cycle in between.
- Priority is evaluated only at grant edges; requests arriving together are served in index order.
- A pending request is never lost. Starvation of low indices under continuous high-priority traffic is accepted.
- `req_tone`/`req_dur` are sampled only at the grant edge; later changes do not affect the playing effect.

## Configuration
- Macro: `SOUND_ARBITER_PREEMPT_EN`.
- **Defined:** in PLAY, if `eff` holds an index strictly lower than the current grant, the arbiter re-grants at the next edge.
  - No gap is inserted.
  - The new effect's `dur_cnt`/`tone` are loaded and its pending bit is cleared.
  - The preempted effect is dropped, not re-queued.
- **Undefined:** no preemption. The current effect always runs to completion.

## Test plan
- **Reset:** assert `reset` mid-PLAY. Every output is 0 asynchronously, and stays at 0 until the first `req` after deassert.
- **Single request:** `req[2]` pulse with tone=4, dur=40. `grant`=4'b0100 for 40 cycles; `aud_pwm` period is 8 cycles, first rise 4 cycles after grant; then 1000 GAP cycles with `aud_sd`=1; then IDLE with all outputs at 0.
- **Simultaneous requests:** `req`=4'b1010 in one cycle. Index 1 plays first and `pending`=4'b1000; index 3 is granted exactly `GAP_CYC` cycles after index 1 ends.
- **Retrigger:** `req[0]` again during its own PLAY. It replays once after the gap; three pulses during PLAY still give only one replay.
- **Zero values:** dur=0, tone=0. `grant` is high for 1 cycle and tone=1 makes `aud_pwm` toggle every cycle; with `GAP_CYC`=0, the next pending effect follows immediately.
- **Preemption:** with `SOUND_ARBITER_PREEMPT_EN`, `req[0]` 10 cycles into a 100-cycle effect for index 3. `grant` switches to 4'b0001 at the next edge and index 3 never resumes. Without the macro, index 3 completes its 100 cycles before index 0 plays.

Source files
------------

// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sharing one square-wave audio output among N_REQ sound-effect requesters.
// Optional macro SOUND_ARBITER_PREEMPT_EN lets a higher-priority request cut the playing effect short.
module sound_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TONE_W  = 16,
   parameter int DUR_W   = 24,
   parameter int GAP_CYC = 1000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*TONE_W-1:0]  req_tone,
   input  logic [N_REQ*DUR_W-1:0]   req_dur,
   output logic [N_REQ-1:0]         grant,
   output logic                     busy,
   output logic [N_REQ-1:0]         pending,
   output logic                     aud_pwm,
   output logic                     aud_sd
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PLAY = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [1:0]        state, nxt_state;
   logic [N_REQ-1:0]  eff, pick_oh, nxt_pending;
   logic [TONE_W-1:0] pick_tone, tone_reg, tone_cnt;
   logic [DUR_W-1:0]  pick_dur, dur_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              pick_vld, grant_now, preempt;

   // A zero duration or half-period is promoted to one cycle.
   function automatic logic [DUR_W-1:0] sat_dur(input logic [DUR_W-1:0] v);
      return (v == '0) ? DUR_W'(1) : v;
   endfunction

   function automatic logic [TONE_W-1:0] sat_tone(input logic [TONE_W-1:0] v);
      return (v == '0) ? TONE_W'(1) : v;
   endfunction

   assign eff      = pending | req;
   assign pick_oh  = eff & (~eff + ONE);
   assign pick_vld = (eff != '0);

   always_comb begin
      pick_tone = '0;
      pick_dur  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) begin
            pick_tone = req_tone[i*TONE_W +: TONE_W];
            pick_dur  = req_dur[i*DUR_W +: DUR_W];
         end
      end
   end

`ifdef SOUND_ARBITER_PREEMPT_EN
   // grant - 1 masks every index with higher priority than the playing one.
   assign preempt = (state == PLAY) && ((eff & (grant - ONE)) != '0);
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      nxt_state = state;
      grant_now = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               grant_now = 1'b1;
               nxt_state = PLAY;
            end
         end
         PLAY: begin
            if (preempt) begin
               grant_now = 1'b1;
            end else if (dur_cnt == DUR_W'(1)) begin
               if (GAP_CYC == 0) begin
                  grant_now = pick_vld;
                  nxt_state = pick_vld ? PLAY : IDLE;
               end else begin
                  nxt_state = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               grant_now = pick_vld;
               nxt_state = pick_vld ? PLAY : IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   assign nxt_pending = eff & ~(grant_now ? pick_oh : '0);
   assign busy        = (state != IDLE);
   assign aud_sd      = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= '0;
         pending  <= '0;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
         tone_cnt <= '0;
         aud_pwm  <= 1'b0;
      end else begin
         state   <= nxt_state;
         pending <= nxt_pending;
         if (grant_now) begin
            grant    <= pick_oh;
            dur_cnt  <= sat_dur(pick_dur);
            tone_cnt <= '0;
            aud_pwm  <= 1'b0;
         end else if ((state == PLAY) && (nxt_state == PLAY)) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
            if (tone_cnt == tone_reg - TONE_W'(1)) begin
               tone_cnt <= '0;
               aud_pwm  <= ~aud_pwm;
            end else begin
               tone_cnt <= tone_cnt + TONE_W'(1);
            end
         end else begin
            grant    <= '0;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            aud_pwm  <= 1'b0;
         end
         gap_cnt <= ((state == GAP) && (nxt_state == GAP)) ? gap_cnt + GAP_W'(1) : '0;
      end
   end

   // Half-period is only consulted in PLAY, which is always entered through a grant load.
   always_ff @(posedge clk) begin
      if (grant_now) tone_reg <= sat_tone(pick_tone);
   end

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter: stimulus queues expected grants, a negedge monitor checks
// grant value, length, gap and tone pattern. Instance 1 runs with GAP_CYC = 0.
module tb_sound_arbiter;

   typedef struct {
      logic [3:0] g;
      int         dur;
      int         gap;
      int         tone;
   } exp_t;

   logic         clk;
   logic         rst0, rst1;
   logic [3:0]   req0, req1;
   logic [15:0]  tone [4];
   logic [23:0]  dur  [4];
   logic [63:0]  req_tone;
   logic [95:0]  req_dur;
   logic [3:0]   grant0, grant1, pending0, pending1;
   logic         busy0, busy1, aud_pwm0, aud_pwm1, aud_sd0, aud_sd1;

   int ntot = 0;
   int nbad = 0;
   exp_t q0[$];
   exp_t q1[$];

   assign req_tone = {tone[3], tone[2], tone[1], tone[0]};
   assign req_dur  = {dur[3], dur[2], dur[1], dur[0]};

   sound_arbiter dut0 (
      .clk(clk), .reset(rst0), .req(req0), .req_tone(req_tone), .req_dur(req_dur),
      .grant(grant0), .busy(busy0), .pending(pending0), .aud_pwm(aud_pwm0), .aud_sd(aud_sd0)
   );

   sound_arbiter #(.GAP_CYC(0)) dut1 (
      .clk(clk), .reset(rst1), .req(req1), .req_tone(req_tone), .req_dur(req_dur),
      .grant(grant1), .busy(busy1), .pending(pending1), .aud_pwm(aud_pwm1), .aud_sd(aud_sd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act_v, input int exp_v);
      ntot++;
      if (act_v != exp_v) begin
         nbad++;
         $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
      end
   endtask

   task automatic pulse(input int u, input logic [3:0] m);
      if (u == 0) req0 = m;
      else        req1 = m;
      @(negedge clk);
      req0 = '0;
      req1 = '0;
   endtask

   // Monitor state, one slot per instance
   logic [3:0] g_a [2];
   logic       p_a [2], b_a [2], s_a [2], r_a [2];
   logic [3:0] pg  [2];
   int         st  [2], fall [2], pwm_bad [2], idle_bad [2];
   bit         act [2];
   exp_t       cur [2];
   exp_t       e;
   bit         emp;
   int         cyc = 0;
   int         k;

   assign g_a[0] = grant0;  assign g_a[1] = grant1;
   assign p_a[0] = aud_pwm0; assign p_a[1] = aud_pwm1;
   assign b_a[0] = busy0;   assign b_a[1] = busy1;
   assign s_a[0] = aud_sd0; assign s_a[1] = aud_sd1;
   assign r_a[0] = rst0;    assign r_a[1] = rst1;

   initial begin
      for (int u = 0; u < 2; u++) begin
         pg[u] = '0; st[u] = 0; fall[u] = 0; pwm_bad[u] = 0; idle_bad[u] = 0; act[u] = 0;
      end
   end

   always @(negedge clk) begin
      cyc++;
      for (int u = 0; u < 2; u++) begin
         if (r_a[u]) begin
            act[u] = 0;
            pg[u]  = '0;
         end else begin
            if (g_a[u] != pg[u]) begin
               if ((pg[u] != '0) && act[u]) begin
                  chk($sformatf("u%0d grant_len", u), cyc - st[u], cur[u].dur);
                  chk($sformatf("u%0d pwm_pattern_errs", u), pwm_bad[u], 0);
                  fall[u] = cyc;
                  act[u]  = 0;
               end
               if (g_a[u] != '0) begin
                  emp = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
                  if (emp) begin
                     ntot++;
                     nbad++;
                     $display("FAIL u%0d unexpected_grant: got %b expected none", u, g_a[u]);
                  end else begin
                     if (u == 0) e = q0.pop_front();
                     else        e = q1.pop_front();
                     chk($sformatf("u%0d grant_value", u), int'(g_a[u]), int'(e.g));
                     if (e.gap >= 0) chk($sformatf("u%0d gap_len", u), cyc - fall[u], e.gap);
                     cur[u]     = e;
                     st[u]      = cyc;
                     act[u]     = 1;
                     pwm_bad[u] = 0;
                  end
               end
            end
            if (act[u]) begin
               k = cyc - st[u];
               if (((k / cur[u].tone) % 2) != int'(p_a[u])) pwm_bad[u]++;
               if (!(b_a[u] && s_a[u])) idle_bad[u]++;
            end else if ((g_a[u] == '0) && p_a[u]) begin
               idle_bad[u]++;
            end
            if (b_a[u] != s_a[u]) idle_bad[u]++;
            pg[u] = g_a[u];
         end
      end
   end

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      req0 = '0;   req1 = '0;
      for (int i = 0; i < 4; i++) begin
         tone[i] = '0;
         dur[i]  = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_grant", int'(grant0), 0);
      chk("rst_pending", int'(pending0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_sd", int'(aud_sd0), 0);
      chk("rst_pwm", int'(aud_pwm0), 0);
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);

      // Single request: tone 4, dur 40, then 1000-cycle gap
      tone[2] = 16'd4; dur[2] = 24'd40;
      q0.push_back('{4'b0100, 40, -1, 4});
      pulse(0, 4'b0100);
      chk("single_busy_now", int'(busy0), 1);
      repeat (540) @(negedge clk);
      chk("gap_busy", int'(busy0), 1);
      chk("gap_sd", int'(aud_sd0), 1);
      chk("gap_grant", int'(grant0), 0);
      chk("gap_pwm", int'(aud_pwm0), 0);
      repeat (510) @(negedge clk);
      chk("idle_busy", int'(busy0), 0);
      chk("idle_sd", int'(aud_sd0), 0);
      chk("idle_grant", int'(grant0), 0);

      // Simultaneous requests 1 and 3; parameters of 1 change mid-play
      tone[1] = 16'd3; dur[1] = 24'd20; tone[3] = 16'd5; dur[3] = 24'd30;
      q0.push_back('{4'b0010, 20, -1, 3});
      q0.push_back('{4'b1000, 30, 1000, 5});
      pulse(0, 4'b1010);
      chk("simul_pending", int'(pending0), 8);
      repeat (5) @(negedge clk);
      tone[1] = 16'd7; dur[1] = 24'd99;
      repeat (2100) @(negedge clk);

      // Retrigger index 0 three times during its own play
      tone[0] = 16'd2; dur[0] = 24'd50;
      q0.push_back('{4'b0001, 50, -1, 2});
      q0.push_back('{4'b0001, 50, 1000, 2});
      pulse(0, 4'b0001);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         pulse(0, 4'b0001);
         @(negedge clk);
      end
      chk("retrig_pending", int'(pending0), 1);
      repeat (2150) @(negedge clk);

      // Zero duration / tone with gap
      tone[1] = '0; dur[1] = 24'd6; tone[2] = '0; dur[2] = '0;
      q0.push_back('{4'b0010, 6, -1, 1});
      q0.push_back('{4'b0100, 1, 1000, 1});
      pulse(0, 4'b0110);
      repeat (2020) @(negedge clk);

      // Zero values with no gap: next pending follows immediately
      tone[0] = '0; dur[0] = '0; tone[2] = 16'd3; dur[2] = 24'd8;
      q1.push_back('{4'b0001, 1, -1, 1});
      q1.push_back('{4'b0100, 8, 0, 3});
      pulse(1, 4'b0101);
      repeat (20) @(negedge clk);
      chk("nogap_idle_busy", int'(busy1), 0);
      chk("nogap_idle_pending", int'(pending1), 0);

      // High-priority request 10 cycles into a 100-cycle effect
      tone[3] = 16'd2; dur[3] = 24'd100; tone[0] = 16'd3; dur[0] = 24'd20;
`ifdef SOUND_ARBITER_PREEMPT_EN
      q0.push_back('{4'b1000, 10, -1, 2});
      q0.push_back('{4'b0001, 20, 0, 3});
`else
      q0.push_back('{4'b1000, 100, -1, 2});
      q0.push_back('{4'b0001, 20, 1000, 3});
`endif
      pulse(0, 4'b1000);
      repeat (9) @(negedge clk);
      pulse(0, 4'b0001);
      repeat (2200) @(negedge clk);

      // Asynchronous reset in the middle of an effect with a request pending
      tone[2] = 16'd4; dur[2] = 24'd200;
      q0.push_back('{4'b0100, 200, -1, 4});
      pulse(0, 4'b0100);
      repeat (5) @(negedge clk);
      pulse(0, 4'b1000);
      chk("pre_rst_pending", int'(pending0), 8);
      repeat (10) @(negedge clk);
      #2 rst0 = 1'b1;
      #1;
      chk("async_rst_grant", int'(grant0), 0);
      chk("async_rst_busy", int'(busy0), 0);
      chk("async_rst_sd", int'(aud_sd0), 0);
      chk("async_rst_pwm", int'(aud_pwm0), 0);
      chk("async_rst_pending", int'(pending0), 0);
      @(negedge clk);
      @(negedge clk);
      rst0 = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_grant", int'(grant0), 0);
      chk("post_rst_busy", int'(busy0), 0);
      chk("post_rst_pending", int'(pending0), 0);

      // Recovery after reset
      tone[1] = 16'd2; dur[1] = 24'd5;
      q0.push_back('{4'b0010, 5, -1, 2});
      pulse(0, 4'b0010);
      repeat (1020) @(negedge clk);

      chk("q0_left", q0.size(), 0);
      chk("q1_left", q1.size(), 0);
      chk("u0_idle_errs", idle_bad[0], 0);
      chk("u1_idle_errs", idle_bad[1], 0);
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
